// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the control sequencer: opcodes, state codes, IR field
// positions, the control-vector payload and the opcode classification helpers.
package cpu_ctrl_pkg;

    localparam int unsigned OPC_W  = 5;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ST_W   = 4;
    localparam int unsigned ALU_W  = 12;
    localparam int unsigned CLS_W  = 3;

    localparam int unsigned OPC_LSB = 27;
    localparam int unsigned RA_LSB  = 23;
    localparam int unsigned RB_LSB  = 19;
    localparam int unsigned RC_LSB  = 15;

    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OPC_W-1:0] OP_SHR  = 5'b00111;
    localparam logic [OPC_W-1:0] OP_SHL  = 5'b01000;
    localparam logic [OPC_W-1:0] OP_ROR  = 5'b01001;
    localparam logic [OPC_W-1:0] OP_ROL  = 5'b01010;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OPC_W-1:0] OP_MFHI = 5'b10111;
    localparam logic [OPC_W-1:0] OP_MFLO = 5'b11000;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b11001;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11010;

    localparam logic [ST_W-1:0] S_IDLE   = 4'd0;
    localparam logic [ST_W-1:0] S_T0     = 4'd1;
    localparam logic [ST_W-1:0] S_T1     = 4'd2;
    localparam logic [ST_W-1:0] S_T2     = 4'd3;
    localparam logic [ST_W-1:0] S_T3     = 4'd4;
    localparam logic [ST_W-1:0] S_T4     = 4'd5;
    localparam logic [ST_W-1:0] S_T5     = 4'd6;
    localparam logic [ST_W-1:0] S_T6     = 4'd7;
    localparam logic [ST_W-1:0] S_HALTED = 4'd8;

    localparam int unsigned ALU_AND = 0;
    localparam int unsigned ALU_OR  = 1;
    localparam int unsigned ALU_ADD = 2;
    localparam int unsigned ALU_SUB = 3;
    localparam int unsigned ALU_MUL = 4;
    localparam int unsigned ALU_DIV = 5;
    localparam int unsigned ALU_SHR = 6;
    localparam int unsigned ALU_SHL = 7;
    localparam int unsigned ALU_ROR = 8;
    localparam int unsigned ALU_ROL = 9;
    localparam int unsigned ALU_NEG = 10;
    localparam int unsigned ALU_NOT = 11;

    localparam logic [CLS_W-1:0] CL_ALU3   = 3'd0;
    localparam logic [CLS_W-1:0] CL_MULDIV = 3'd1;
    localparam logic [CLS_W-1:0] CL_UNARY  = 3'd2;
    localparam logic [CLS_W-1:0] CL_MFHI   = 3'd3;
    localparam logic [CLS_W-1:0] CL_MFLO   = 3'd4;
    localparam logic [CLS_W-1:0] CL_NOP    = 3'd5;
    localparam logic [CLS_W-1:0] CL_HALT   = 3'd6;
    localparam logic [CLS_W-1:0] CL_ILL    = 3'd7;

    typedef struct packed {
        logic             pc_out;
        logic             zhi_out;
        logic             zlo_out;
        logic             mdr_out;
        logic             hi_out;
        logic             lo_out;
        logic             mar_in;
        logic             z_in;
        logic             pc_in;
        logic             mdr_in;
        logic             ir_in;
        logic             y_in;
        logic             hi_in;
        logic             lo_in;
        logic             inc_pc;
        logic             read;
        logic             gra;
        logic             grb;
        logic             grc;
        logic             r_in;
        logic             r_out;
        logic             illegal;
        logic [ALU_W-1:0] alu;
    } ctrl_t;

    function automatic logic [CLS_W-1:0] op_class(input logic [OPC_W-1:0] opc);
        logic [CLS_W-1:0] cls;
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls = CL_ALU3;
            OP_MUL, OP_DIV:                 cls = CL_MULDIV;
            OP_NEG, OP_NOT:                 cls = CL_UNARY;
            OP_MFHI:                        cls = CL_MFHI;
            OP_MFLO:                        cls = CL_MFLO;
            OP_NOP:                         cls = CL_NOP;
            OP_HALT:                        cls = CL_HALT;
            default:                        cls = CL_ILL;
        endcase
        return cls;
    endfunction

    // Final execute step of each class; everything not listed finishes in T3.
    function automatic logic [ST_W-1:0] last_state(input logic [CLS_W-1:0] cls);
        logic [ST_W-1:0] st;
        case (cls)
            CL_ALU3:   st = S_T5;
            CL_MULDIV: st = S_T6;
            CL_UNARY:  st = S_T4;
            default:   st = S_T3;
        endcase
        return st;
    endfunction

    function automatic logic [ALU_W-1:0] alu_sel(input logic [OPC_W-1:0] opc);
        logic [ALU_W-1:0] sel;
        sel = '0;
        case (opc)
            OP_AND: sel[ALU_AND] = 1'b1;
            OP_OR:  sel[ALU_OR]  = 1'b1;
            OP_ADD: sel[ALU_ADD] = 1'b1;
            OP_SUB: sel[ALU_SUB] = 1'b1;
            OP_MUL: sel[ALU_MUL] = 1'b1;
            OP_DIV: sel[ALU_DIV] = 1'b1;
            OP_SHR: sel[ALU_SHR] = 1'b1;
            OP_SHL: sel[ALU_SHL] = 1'b1;
            OP_ROR: sel[ALU_ROR] = 1'b1;
            OP_ROL: sel[ALU_ROL] = 1'b1;
            OP_NEG: sel[ALU_NEG] = 1'b1;
            OP_NOT: sel[ALU_NOT] = 1'b1;
            default: sel = '0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational map of (state, opcode) to the full datapath control vector.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [ST_W-1:0]  state_i,
    input  logic [OPC_W-1:0] opc_i,
    output ctrl_t            ctrl_o
);

    logic [CLS_W-1:0] cls_c;
    logic [ALU_W-1:0] alu_c;

    assign cls_c = op_class(opc_i);
    assign alu_c = alu_sel(opc_i);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_T0: begin
                ctrl_o.pc_out = 1'b1;
                ctrl_o.mar_in = 1'b1;
                ctrl_o.inc_pc = 1'b1;
            end
            S_T1: begin
                ctrl_o.read   = 1'b1;
                ctrl_o.mdr_in = 1'b1;
            end
            S_T2: begin
                ctrl_o.mdr_out = 1'b1;
                ctrl_o.ir_in   = 1'b1;
            end
            S_T3: begin
                case (cls_c)
                    CL_ALU3: begin
                        ctrl_o.grb   = 1'b1;
                        ctrl_o.r_out = 1'b1;
                        ctrl_o.y_in  = 1'b1;
                    end
                    CL_MULDIV: begin
                        ctrl_o.gra   = 1'b1;
                        ctrl_o.r_out = 1'b1;
                        ctrl_o.y_in  = 1'b1;
                    end
                    CL_UNARY: begin
                        ctrl_o.grb   = 1'b1;
                        ctrl_o.r_out = 1'b1;
                        ctrl_o.alu   = alu_c;
                        ctrl_o.z_in  = 1'b1;
                    end
                    CL_MFHI: begin
                        ctrl_o.hi_out = 1'b1;
                        ctrl_o.gra    = 1'b1;
                        ctrl_o.r_in   = 1'b1;
                    end
                    CL_MFLO: begin
                        ctrl_o.lo_out = 1'b1;
                        ctrl_o.gra    = 1'b1;
                        ctrl_o.r_in   = 1'b1;
                    end
                    CL_ILL:  ctrl_o.illegal = 1'b1;
                    default: ctrl_o = '0;
                endcase
            end
            S_T4: begin
                case (cls_c)
                    CL_ALU3: begin
                        ctrl_o.grc   = 1'b1;
                        ctrl_o.r_out = 1'b1;
                        ctrl_o.alu   = alu_c;
                        ctrl_o.z_in  = 1'b1;
                    end
                    CL_MULDIV: begin
                        ctrl_o.grb   = 1'b1;
                        ctrl_o.r_out = 1'b1;
                        ctrl_o.alu   = alu_c;
                        ctrl_o.z_in  = 1'b1;
                    end
                    CL_UNARY: begin
                        ctrl_o.zlo_out = 1'b1;
                        ctrl_o.gra     = 1'b1;
                        ctrl_o.r_in    = 1'b1;
                    end
                    default: ctrl_o = '0;
                endcase
            end
            S_T5: begin
                case (cls_c)
                    CL_ALU3: begin
                        ctrl_o.zlo_out = 1'b1;
                        ctrl_o.gra     = 1'b1;
                        ctrl_o.r_in    = 1'b1;
                    end
                    CL_MULDIV: begin
                        ctrl_o.zlo_out = 1'b1;
                        ctrl_o.lo_in   = 1'b1;
                    end
                    default: ctrl_o = '0;
                endcase
            end
            S_T6: begin
                if (cls_c == CL_MULDIV) begin
                    ctrl_o.zhi_out = 1'b1;
                    ctrl_o.hi_in   = 1'b1;
                end
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control unit: fetch T0-T2, opcode-dependent execute T3-T6,
// run/halt handshake and memory-ready stall in the read cycle.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic              Clock,
    input  logic              Clear,
    input  logic              Strt,
    input  logic [DATA_W-1:0] IR,
    input  logic              Mem_ready,
    output logic              Run,
    output logic              Illegal,
    output logic              PCout,
    output logic              Zhiout,
    output logic              Zlowout,
    output logic              MDRout,
    output logic              HIout,
    output logic              LOout,
    output logic              MARin,
    output logic              Zin,
    output logic              PCin,
    output logic              MDRin,
    output logic              IRin,
    output logic              Yin,
    output logic              HIin,
    output logic              LOin,
    output logic              IncPC,
    output logic              Read,
    output logic              Gra,
    output logic              Grb,
    output logic              Grc,
    output logic              Rin,
    output logic              Rout,
    output logic              AND,
    output logic              OR,
    output logic              ADD,
    output logic              SUB,
    output logic              MUL,
    output logic              DIV,
    output logic              SHR,
    output logic              SHL,
    output logic              ROR,
    output logic              ROL,
    output logic              NEG,
    output logic              NOT
);

    logic [ST_W-1:0]  state_q, state_d;
    logic             run_q, run_d;
    logic             armed_q;
    logic [OPC_W-1:0] opc_c;
    logic [ST_W-1:0]  last_c;
    logic             start_ok_c;
    logic             ir_unused_c;
    ctrl_t            ctrl_c;

    // Register fields are consumed by the datapath, not by the sequencer.
    assign opc_c       = IR[OPC_LSB +: OPC_W];
    assign ir_unused_c = ^IR[OPC_LSB-1:0];
    assign last_c      = last_state(op_class(opc_c));
    // armed_q blocks a Strt that arrives on the first edge after Clear releases.
    assign start_ok_c  = Strt && armed_q;

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start_ok_c) begin
                    state_d = S_T0;
                    run_d   = 1'b1;
                end
            end
            S_T0: state_d = S_T1;
            S_T1: if (Mem_ready) state_d = S_T2;
            S_T2: state_d = S_T3;
            S_T3, S_T4, S_T5, S_T6: begin
                // >= keeps the sequence bounded if IR changes mid-execute.
                if (state_q >= last_c) begin
                    if (opc_c == OP_HALT) begin
                        state_d = S_HALTED;
                        run_d   = 1'b0;
                    end else begin
                        state_d = S_T0;
                    end
                end else begin
                    state_d = state_q + ST_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                run_d   = 1'b0;
            end
        endcase
    end

    ctrl_decode u_decode (
        .state_i (state_q),
        .opc_i   (opc_c),
        .ctrl_o  (ctrl_c)
    );

    assign Run     = run_q;
    assign Illegal = ctrl_c.illegal;
    assign PCout   = ctrl_c.pc_out;
    assign Zhiout  = ctrl_c.zhi_out;
    assign Zlowout = ctrl_c.zlo_out;
    assign MDRout  = ctrl_c.mdr_out;
    assign HIout   = ctrl_c.hi_out;
    assign LOout   = ctrl_c.lo_out;
    assign MARin   = ctrl_c.mar_in;
    assign Zin     = ctrl_c.z_in;
    assign PCin    = ctrl_c.pc_in;
    assign MDRin   = ctrl_c.mdr_in;
    assign IRin    = ctrl_c.ir_in;
    assign Yin     = ctrl_c.y_in;
    assign HIin    = ctrl_c.hi_in;
    assign LOin    = ctrl_c.lo_in;
    assign IncPC   = ctrl_c.inc_pc;
    assign Read    = ctrl_c.read;
    assign Gra     = ctrl_c.gra;
    assign Grb     = ctrl_c.grb;
    assign Grc     = ctrl_c.grc;
    assign Rin     = ctrl_c.r_in;
    assign Rout    = ctrl_c.r_out;
    assign AND     = ctrl_c.alu[ALU_AND];
    assign OR      = ctrl_c.alu[ALU_OR];
    assign ADD     = ctrl_c.alu[ALU_ADD];
    assign SUB     = ctrl_c.alu[ALU_SUB];
    assign MUL     = ctrl_c.alu[ALU_MUL];
    assign DIV     = ctrl_c.alu[ALU_DIV];
    assign SHR     = ctrl_c.alu[ALU_SHR];
    assign SHL     = ctrl_c.alu[ALU_SHL];
    assign ROR     = ctrl_c.alu[ALU_ROR];
    assign ROL     = ctrl_c.alu[ALU_ROL];
    assign NEG     = ctrl_c.alu[ALU_NEG];
    assign NOT     = ctrl_c.alu[ALU_NOT];

    // Single bus: one driver and one register-field select at a time.
    a_bus_excl: assert property (@(posedge Clock) disable iff (!Clear)
        $onehot0({PCout, Zhiout, Zlowout, MDRout, HIout, LOout, Rout}) &&
        $onehot0({Gra, Grb, Grc}));

    a_alu_sel: assert property (@(posedge Clock) disable iff (!Clear)
        (Zin ? $onehot(ctrl_c.alu) : (ctrl_c.alu == '0)));

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: cycle-by-cycle strobe checks against
// hand-built expected vectors.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Clear;
    logic        Strt;
    logic [31:0] IR;
    logic        Mem_ready;
    logic Run, Illegal, PCout, Zhiout, Zlowout, MDRout, HIout, LOout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, IncPC, Read;
    logic Gra, Grb, Grc, Rin, Rout;
    logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT;

    int n_pass = 0;
    int n_total = 0;

    logic [34:0] obs;
    assign obs = {Run, Illegal, PCout, Zhiout, Zlowout, MDRout, HIout, LOout,
                  MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, IncPC, Read,
                  Gra, Grb, Grc, Rin, Rout,
                  AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT};

    localparam logic [34:0] B_NOT   = 35'(1) << 0;
    localparam logic [34:0] B_NEG   = 35'(1) << 1;
    localparam logic [34:0] B_SUB   = 35'(1) << 8;
    localparam logic [34:0] B_ADD   = 35'(1) << 9;
    localparam logic [34:0] B_MUL   = 35'(1) << 7;
    localparam logic [34:0] B_ROUT  = 35'(1) << 12;
    localparam logic [34:0] B_RIN   = 35'(1) << 13;
    localparam logic [34:0] B_GRC   = 35'(1) << 14;
    localparam logic [34:0] B_GRB   = 35'(1) << 15;
    localparam logic [34:0] B_GRA   = 35'(1) << 16;
    localparam logic [34:0] B_READ  = 35'(1) << 17;
    localparam logic [34:0] B_INCPC = 35'(1) << 18;
    localparam logic [34:0] B_LOIN  = 35'(1) << 19;
    localparam logic [34:0] B_HIIN  = 35'(1) << 20;
    localparam logic [34:0] B_YIN   = 35'(1) << 21;
    localparam logic [34:0] B_IRIN  = 35'(1) << 22;
    localparam logic [34:0] B_MDRIN = 35'(1) << 23;
    localparam logic [34:0] B_ZIN   = 35'(1) << 25;
    localparam logic [34:0] B_MARIN = 35'(1) << 26;
    localparam logic [34:0] B_HIOUT = 35'(1) << 28;
    localparam logic [34:0] B_MDROUT= 35'(1) << 29;
    localparam logic [34:0] B_ZLOUT = 35'(1) << 30;
    localparam logic [34:0] B_ZHOUT = 35'(1) << 31;
    localparam logic [34:0] B_PCOUT = 35'(1) << 32;
    localparam logic [34:0] B_ILL   = 35'(1) << 33;
    localparam logic [34:0] B_RUN   = 35'(1) << 34;

    localparam logic [34:0] E_T0 = B_RUN | B_PCOUT | B_MARIN | B_INCPC;
    localparam logic [34:0] E_T1 = B_RUN | B_READ | B_MDRIN;
    localparam logic [34:0] E_T2 = B_RUN | B_MDROUT | B_IRIN;

    control_sequencer dut (
        .Clock(Clock), .Clear(Clear), .Strt(Strt), .IR(IR), .Mem_ready(Mem_ready),
        .Run(Run), .Illegal(Illegal), .PCout(PCout), .Zhiout(Zhiout),
        .Zlowout(Zlowout), .MDRout(MDRout), .HIout(HIout), .LOout(LOout),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV),
        .SHR(SHR), .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [34:0] got, input logic [34:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %09h expected %09h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Assumes the DUT is in T0; checks fetch and leaves it in T3.
    task automatic fetch(input string tag);
        chk({tag, "_t0"}, obs, E_T0);
        step();
        chk({tag, "_t1"}, obs, E_T1);
        step();
        chk({tag, "_t2"}, obs, E_T2);
        step();
    endtask

    initial begin
        Clear = 1'b0; Strt = 1'b0; IR = 32'h0; Mem_ready = 1'b1;
        step();
        step();
        chk("reset", obs, '0);
        Clear = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle", obs, '0);
        end

        // ADD Ra=5 Rb=2 Rc=4
        IR = 32'h1A92_0000;
        Strt = 1'b1;
        step();
        Strt = 1'b0;
        fetch("add");
        chk("add_t3", obs, B_RUN | B_GRB | B_ROUT | B_YIN);
        step();
        chk("add_t4", obs, B_RUN | B_GRC | B_ROUT | B_ADD | B_ZIN);
        step();
        chk("add_t5", obs, B_RUN | B_ZLOUT | B_GRA | B_RIN);
        step();

        // MUL with a 3-cycle memory stall in T1
        chk("mul_t0", obs, E_T0);
        Mem_ready = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("stall_t1", obs, E_T1);
            step();
        end
        Mem_ready = 1'b1;
        chk("stall_t1_last", obs, E_T1);
        IR = 32'h7800_0000;
        step();
        chk("stall_t2", obs, E_T2);
        step();
        chk("mul_t3", obs, B_RUN | B_GRA | B_ROUT | B_YIN);
        step();
        chk("mul_t4", obs, B_RUN | B_GRB | B_ROUT | B_MUL | B_ZIN);
        step();
        chk("mul_t5", obs, B_RUN | B_ZLOUT | B_LOIN);
        step();
        chk("mul_t6", obs, B_RUN | B_ZHOUT | B_HIIN);
        step();

        // Undefined opcode 11111
        IR = 32'hF800_0000;
        fetch("ill");
        chk("ill_t3", obs, B_RUN | B_ILL);
        step();

        // NEG then MFHI
        IR = 32'h8800_0000;
        fetch("neg");
        chk("neg_t3", obs, B_RUN | B_GRB | B_ROUT | B_NEG | B_ZIN);
        step();
        chk("neg_t4", obs, B_RUN | B_ZLOUT | B_GRA | B_RIN);
        step();
        IR = 32'hB800_0000;
        fetch("mfhi");
        chk("mfhi_t3", obs, B_RUN | B_HIOUT | B_GRA | B_RIN);
        step();

        // HALT, then restart
        IR = 32'hD000_0000;
        fetch("halt");
        chk("halt_t3", obs, B_RUN);
        step();
        chk("halted", obs, '0);
        step();
        chk("halted_hold", obs, '0);
        Strt = 1'b1;
        step();
        Strt = 1'b0;
        chk("restart_t0", obs, E_T0);
        step();
        step();
        IR = 32'h2000_0000;
        step();

        // SUB interrupted by Clear in T4
        chk("sub_t3", obs, B_RUN | B_GRB | B_ROUT | B_YIN);
        step();
        chk("sub_t4", obs, B_RUN | B_GRC | B_ROUT | B_SUB | B_ZIN);
        #2;
        Clear = 1'b0;
        #1;
        chk("async_clear", obs, '0);
        @(posedge Clock);
        #1;
        Clear = 1'b1;
        Strt = 1'b1;
        step();
        chk("strt_at_release", obs, '0);
        Strt = 1'b0;
        step();
        chk("post_release_idle", obs, '0);
        Strt = 1'b1;
        step();
        Strt = 1'b0;
        chk("start_after_clear", obs, E_T0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Multi-cycle control unit that sits directly upstream of the single-bus datapath. It drives every bus-enable, register-load, memory and ALU-select strobe the datapath consumes. It steps through fetch (T0–T2) and an opcode-dependent execute sequence (T3–T6) using IR fed back from the datapath. It also provides a run/halt handshake with the testbench or system and a memory-ready stall in the read cycle.

Parameters:
OPC_W, 5, opcode width (IR[31:27])
REG_W, 4, register-field width (Ra IR[26:23], Rb IR[22:19], Rc IR[18:15])
DATA_W, 32, IR width

Ports:
Clock  in  1  system clock, rising edge
Clear  in  1  asynchronous, active-low reset
Strt  in  1  one-cycle pulse; starts or restarts execution from IDLE/HALTED
IR  in  DATA_W  current instruction register contents
Mem_ready  in  1  memory has valid read data this cycle
Run  out  1  high while executing instructions
Illegal  out  1  one-cycle pulse on an undefined opcode
PCout, Zhiout, Zlowout, MDRout, HIout, LOout  out  1 each  bus drive enables
MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin  out  1 each  register loads
IncPC, Read  out  1 each  PC increment; memory read / MDR source select
Gra, Grb, Grc, Rin, Rout  out  1 each  register-field select and GPR in/out strobes
AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT  out  1 each  one-hot ALU op select

Behaviour:
- State register: IDLE, T0..T6, HALTED. It is encoded in the package. Clear low forces IDLE asynchronously, mid-instruction included.
- Moore outputs decode from state and IR only. In IDLE/HALTED every output is 0 except Run=0. After reset, all outputs are 0.
- Run is registered. It sets on the cycle after Strt in IDLE/HALTED and clears on entry to HALTED. Strt is ignored while Run=1.
- T0: PCout, MARin, IncPC. Go to T1.
- T1: Read, MDRin. Hold in T1 while Mem_ready=0, with strobes held. Go to T2 on the first cycle where Mem_ready=1.
- T2: MDRout, IRin. Go to T3. IR is valid from T3 onward.
- 3-operand ALU ops (ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHL 01000, ROR 01001, ROL 01010):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, op, Zin.
  - T5: Zlowout, Gra, Rin. Then T0. Total 6 cycles with no wait.
- MUL 01111 / DIV 10000:
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, op, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhiout, HIin. Then T0.
- NEG 10001 / NOT 10010:
  - T3: Grb, Rout, op, Zin.
  - T4: Zlowout, Gra, Rin. Then T0.
- MFHI 10111: T3: HIout, Gra, Rin. Then T0.
- MFLO 11000: T3: LOout, Gra, Rin. Then T0.
- NOP 11001: T3 with no strobes. Then T0.
- HALT 11010: T3 with no strobes. Then HALTED, Run falls.
- Any other opcode is handled as NOP and Illegal=1 during T3 only.
- Exactly one ALU op line is high in any cycle, and only during the cycle carrying Zin. At most one *out enable and at most one of Gra/Grb/Grc is high per cycle (bus exclusivity). This is an assertion target.
- Strt and Mem_ready are consumed synchronously. Strt asserted the same cycle Clear releases is ignored.
- Decoder uses IR[31:27] combinationally in T3..T6. Changes to IR after T2 are not expected. If they occur, the decoder follows IR, with no latching.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams (OP_ADD … OP_HALT)
  - state encoding (S_IDLE, S_T0..S_T6, S_HALTED)
  - field bit positions for opcode, Ra, Rb and Rc
- One sub-module, ctrl_decode: purely combinational map of (state, opcode) to the control vector. The top holds the state register, Run, the stall and next-state logic.

Test Plan:
1. Clear=0 for 2 cycles, then 1 with no Strt -> all outputs 0, Run=0, state IDLE for 10 cycles.
2. Strt pulse, Mem_ready=1, IR=0x1A920000 (ADD Ra=5, Rb=2, Rc=4) -> cycle-by-cycle strobes:
   - T0: PCout/MARin/IncPC
   - T1: Read/MDRin
   - T2: MDRout/IRin
   - T3: Grb/Rout/Yin
   - T4: Grc/Rout/ADD/Zin
   - T5: Zlowout/Gra/Rin
   - T0 again on cycle 7.
3. Mem_ready low 3 cycles during T1 -> Read/MDRin held 4 cycles; IRin appears exactly one cycle after Mem_ready rises.
4. IR opcode MUL (0x78000000) -> T5 Zlowout+LOin, T6 Zhiout+HIin, then T0; opcode 11111 -> Illegal pulse 1 cycle in T3, then T0.
5. HALT (0xD0000000) -> Run falls the cycle after T3, outputs idle; Strt pulse -> Run=1 and T0 strobes next cycle.
6. Clear driven low while in T4 of a SUB -> all outputs 0 immediately (asynchronously), Run=0; release -> IDLE.
